// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encoding, default
// latencies and the HI/LO pair type.
package mdu_defs;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int CNT_W           = 16;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO; the result is
// computed at accept into shadow registers and committed after the latency count.
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            arch_q, arch_d;
  hilo_t            shadow_q, shadow_d;
  logic             dz_q, dz_d;

  logic               accept;
  logic               div_ovf;
  logic [31:0]        b_nz;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] quo_s, rem_s;
  hilo_t              result;

  assign busy   = (state_q == ST_RUN);
  assign accept = start && !busy && (is_mul_op(MDUOp) || is_div_op(MDUOp));

  // Divisor forced non-zero so the datapath never divides by zero; the
  // dz flag suppresses the commit instead.
  assign b_nz    = (B == 32'd0) ? 32'd1 : B;
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign quo_s  = div_ovf ? $signed(A) : $signed(A) / $signed(b_nz);
  assign rem_s  = div_ovf ? 32'sd0     : $signed(A) % $signed(b_nz);

  always_comb begin
    result = '0;
    case (MDUOp)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = {rem_s, quo_s};
      MDU_DIVU:  result = {A % b_nz, A / b_nz};
      default:   result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arch_d   = arch_q;
    shadow_d = shadow_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_RUN;
          cnt_d    = is_mul_op(MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          shadow_d = result;
          dz_d     = is_div_op(MDUOp) && (B == 32'd0);
        end else if (MDUOp == MDU_MTHI) begin
          arch_d.hi = A;
        end else if (MDUOp == MDU_MTLO) begin
          arch_d.lo = A;
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!dz_q) arch_d = shadow_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      arch_q   <= '0;
      shadow_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arch_q   <= arch_d;
      shadow_q <= shadow_d;
      dz_q     <= dz_d;
    end
  end

  assign HI = arch_q.hi;
  assign LO = arch_q.lo;
  assign RD = (MDUOp == MDU_MFHI) ? arch_q.hi :
              (MDUOp == MDU_MFLO) ? arch_q.lo : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO queued at issue, popped and
// compared when busy drops.
module tb_mdu;
  import mdu_defs::*;

  localparam int NMUL = 5;
  localparam int NDIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  MDUOp = MDU_NONE;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO, RD;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .RD(RD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      MDU_MULT:  res = 64'(sa * sb);
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      MDU_DIVU:  res = {a % b, a / b};
      default:   res = '0;
    endcase
    return res;
  endfunction

  // Wait for busy to drop (bounded), then check latency and the committed pair.
  task automatic finish_op(input string tag, input int n, input int already);
    int cyc;
    logic [63:0] e;
    cyc = already;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, "_cycles"}, 64'(cyc), 64'(n));
    e = exp_q.pop_front();
    chk({tag, "_hi"}, {32'd0, HI}, {32'd0, e[63:32]});
    chk({tag, "_lo"}, {32'd0, LO}, {32'd0, e[31:0]});
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int n);
    exp_q.push_back(exp);
    start = 1'b1; MDUOp = op; A = a; B = b;
    tick();
    start = 1'b0; MDUOp = MDU_NONE;
    A = $urandom; B = $urandom;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    finish_op(tag, n, 0);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    MDUOp = op; A = a;
    tick();
    MDUOp = MDU_NONE;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b0;
    tick();
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, HI}, 64'd0);
    chk("rst_lo", {32'd0, LO}, 64'd0);
    chk("rst_rd", {32'd0, RD}, 64'd0);
    reset = 1'b1;

    mt(MDU_MTHI, 32'h1234_5678);
    chk("mthi_hi", {32'd0, HI}, 64'h1234_5678);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    MDUOp = MDU_MFHI; #1;
    chk("mfhi_rd", {32'd0, RD}, 64'h1234_5678);
    MDUOp = MDU_MFLO; #1;
    chk("mflo_rd", {32'd0, RD}, 64'd0);
    MDUOp = MDU_NONE;

    run_op("mult",  MDU_MULT,  32'hFFFF_FFFD, 32'd5,  64'hFFFF_FFFF_FFFF_FFF1, NMUL);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2,  64'h0000_0001_FFFF_FFFE, NMUL);
    run_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,  64'hFFFF_FFFF_FFFF_FFFD, NDIV);
    run_op("divu",  MDU_DIVU,  32'd7,         32'd2,  64'h0000_0001_0000_0003, NDIV);
    run_op("divovf", MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, NDIV);
    MDUOp = MDU_MFLO; #1;
    chk("mflo_after_commit", {32'd0, RD}, 64'h8000_0000);
    MDUOp = MDU_NONE;

    mt(MDU_MTHI, 32'hAA);
    mt(MDU_MTLO, 32'hBB);
    run_op("divz", MDU_DIVU, 32'd7, 32'd0, 64'h0000_00AA_0000_00BB, NDIV);

    start = 1'b1; MDUOp = MDU_MFHI;
    tick();
    start = 1'b0; MDUOp = MDU_NONE;
    chk("start_nonarith", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      rop = 4'(MDU_MULT + 4'($urandom_range(0, 3)));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'd0) rb = 32'd3;
      if (i == 1) rb = 32'd0 - 32'($urandom_range(1, 100));
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb),
             is_mul_op(rop) ? NMUL : NDIV);
    end

    // Second start during the first multiply must be ignored.
    exp_q.push_back(64'd6);
    start = 1'b1; MDUOp = MDU_MULT; A = 32'd2; B = 32'd3;
    tick();
    start = 1'b0; MDUOp = MDU_NONE;
    tick();
    start = 1'b1; MDUOp = MDU_MULT; A = 32'd4; B = 32'd4;
    tick();
    start = 1'b0; MDUOp = MDU_NONE;
    chk("ovl_busy", {63'd0, busy}, 64'd1);
    finish_op("ovl", NMUL, 2);

    start = 1'b1; MDUOp = MDU_DIV; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; MDUOp = MDU_NONE;
    tick(); tick(); tick();
    chk("abort_busy_pre", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, HI}, 64'd0);
    chk("abort_lo", {32'd0, LO}, 64'd0);
    repeat (12) tick();
    chk("abort_late_busy", {63'd0, busy}, 64'd0);
    chk("abort_late_hi", {32'd0, HI}, 64'd0);
    chk("abort_late_lo", {32'd0, LO}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit beside the ALU in the single-cycle MIPS datapath. It consumes the two GRF read operands (rs, rt) and holds results in architectural HI/LO registers. It exposes `busy` so the controller can stall any instruction that touches HI/LO while an operation is in flight. It implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low; state clears on a `clk` edge while `reset`=0
- `start`  in  1  start mult/multu/div/divu this cycle
- `MDUOp`  in  4  operation select; encoding in package
- `A`  in  32  rs operand (GRFRD1)
- `B`  in  32  rt operand (GRFRD2)
- `busy`  out  1  operation in flight
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `RD`  out  32  combinational read: HI when `MDUOp`=MFHI, LO when MFLO, else 0

## Operation
- Ops: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- `start`=1 with `MDUOp` ∈ {MULT, MULTU, DIV, DIVU} and `busy`=0 is accepted at that edge:
  - MULT/MULTU: 64-bit signed/unsigned product `{hi,lo}` latched into shadow registers.
  - DIV/DIVU: signed/unsigned quotient → shadow lo, remainder → shadow hi.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
- `start` with any other `MDUOp` is ignored.
- `start` while `busy`=1 is ignored; the in-flight operation is unaffected.
- Divide by zero (B=0, div or divu): accepted and runs the full DIV_CYCLES; HI/LO are not updated at completion.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO with `busy`=0: HI/LO ← A at the edge; `start` is not required.
- MTHI/MTLO with `busy`=1: ignored. The controller guarantees this does not occur by stalling.
- MFHI/MFLO: purely combinational via `RD`; the GRF write happens in the datapath.
- States:
  - IDLE (`busy`=0)
  - RUN (`busy`=1, counter decrementing)
  - Transitions: IDLE→RUN on accept; RUN→IDLE at the edge where counter=1, which commits the shadow registers to HI/LO.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0, counter=0, shadows=0.
- Reset mid-operation: the operation is aborted; HI/LO=0 and `busy`=0 after that edge.
- Accept at edge E0:
  - `busy`=1 from E0 through edge E0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take the new value at E0+N; `busy`=0 after E0+N.
  - A new `start` is first accepted at edge E0+N+1. No back-to-back overlap.
- Controller stall rule: stall any MDU instruction while (`busy` | `start`).
- `A`/`B` are sampled only at the accept edge; later changes have no effect.
- `RD` has zero latency from `MDUOp` and HI/LO. `RD` after a commit edge shows the new value.
- All arithmetic is 32×32→64; results are exact with no saturation.

## Structure
- Shared package (`mdu_defs`):
  - `MDUOp` encoding constants: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - Default cycle constants.
- The 6-bit controller `Func`→`MDUOp` mapping belongs in the controller, not here.
- Single module; no sub-module needed. Arithmetic uses behavioural `*`, `/`, `%` on the sampled operands. Cycle counts model latency only.

## Test plan
- Reset low for 2 edges, then MTHI A=0x12345678 → HI=0x12345678, `busy` stays 0; `RD`=0x12345678 with MFHI.
- MULT A=0xFFFFFFFD (−3), B=5 → `busy` for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU A=0xFFFFFFFF, B=2 → HI=1, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- DIVU A=7, B=0 with HI=0xAA, LO=0xBB → `busy` for 10 cycles; HI/LO unchanged.
- MULT 2×3 accepted, then `start` MULT 4×4 on cycle 2 → second op ignored; LO=6, `busy` drops at cycle 5.
- DIV in flight, `reset`=0 at cycle 4 → next edge `busy`=0, HI=LO=0; no later commit occurs.
